sha256_compress: RTL and testbench
==================================

// Module: sha256_compress
// PURPOSE
//  Multicycle SHA-256 single-block compression engine for the crypto coprocessor.
//  Accepts 16 pre-padded big-endian message words, runs ROUNDS rounds, adds the result into the chaining state H0..H7.
//  Does not compute sig0/sig1/sum0/sum1 itself; it drives the shared sha256 primitive unit through sha_opcode/sha_rs1/sha_rd, one op per cycle.
//  Exposes the 256-bit chaining digest.
// PARAMETERS
//  ROUNDS  64  Rounds per block. Legal range is 16..64; values below 64 exist for sim debug only.
// PORTS
//  clk         in   1    Clock.
//  rst         in   1    Synchronous, active-high reset.
//  init        in   1    Load H with the FIPS 180-4 IV. Honoured in IDLE only.
//  msg_valid   in   1    msg_word is valid.
//  msg_ready   out  1    Engine accepts a word on this edge if msg_valid is also high.
//  msg_word    in   32   Message word; W0 first, W15 last.
//  busy        out  1    High in ROUND and FINAL.
//  done        out  1    Single-cycle pulse; digest has been updated.
//  digest      out  256  {H0..H7}; H0 occupies [255:224].
//  sha_opcode  out  2    Op to the primitive unit: `SHA256_SIG0/SIG1/SUM0/SUM1 from core/defs.v.
//  sha_rs1     out  32   Operand to the primitive unit.
//  sha_rd      in   32   Primitive result; combinational and valid in the same cycle.
// BEHAVIOUR
//  Reset
//   - state=IDLE; H=IV (so digest=6a09e667..5be0cd19); done=0.
//   - Word counter, round counter t and sub-step are 0.
//   - sha_opcode=2'b00 and sha_rs1=0.
//   - msg_ready=0 while rst is high.
//  Handshake
//   - msg_ready = (state==IDLE || state==LOAD) && !init.
//   - A word is accepted when msg_valid && msg_ready at an edge. It is written to W[cnt] and cnt increments.
//   - The first accepted word moves IDLE to LOAD.
//   - Accepting word 15 moves to ROUND with t=0 and step=SUM1.
//   - Words presented while busy are not consumed.
//  init
//   - In IDLE: on an edge with init=1, H<=IV. No word is accepted that cycle.
//   - In LOAD, ROUND or FINAL: init is ignored.
//   - Without init, the next block chains on the current H (multi-block messages).
//  ROUND sub-steps, one cycle each
//   - Steps for t>=16: SIG0 -> SIG1 -> SUM1 -> SUM0.
//   - Steps for t<16: SUM1 -> SUM0 only.
//   - SIG0: opcode=SIG0, rs1=W[(t-15)%16]. Latch s0<=sha_rd.
//   - SIG1: opcode=SIG1, rs1=W[(t-2)%16]. W[t%16] <= sha_rd + W[(t-7)%16] + s0 + W[t%16] (mod 2^32).
//   - SUM1: opcode=SUM1, rs1=e. Latch s1<=sha_rd.
//   - SUM0: opcode=SUM0, rs1=a.
//   - SUM0 update: T1=h+s1+Ch(e,f,g)+K[t]+W[t%16]; T2=sha_rd+Maj(a,b,c).
//   - SUM0 update: {a..h} <= {T1+T2, a, b, c, d+T1, e, f, g}; t++.
//   - After SUM0 of t=ROUNDS-1, go to FINAL.
//   - All adds are 32-bit and wrap.
//   - K is the 64-entry constant ROM.
//   - a..h load from H on entry to ROUND.
//  FINAL, one cycle
//   - Hi <= Hi + working_i (mod 2^32); done<=1; return to IDLE.
//   - done is high for exactly the next cycle.
//  Latency
//   - Edges from the word-15 accept to the edge raising done = 2*16 + 4*(ROUNDS-16) + 1.
//   - That is 225 for ROUNDS=64.
//   - msg_ready is back high in the cycle done is high.
//  Primitive bus
//   - In IDLE, LOAD and FINAL: sha_opcode=2'b00 and sha_rs1=0.
//   - sha_rd is ignored outside SIG0/SIG1/SUM1/SUM0 steps.
//  Mid-operation reset
//   - rst in any state aborts the block: H<=IV, no done pulse, partial words discarded.
// TESTING
//  T1 "abc": init, then W0=61626380, W1..W14=0, W15=00000018.
//     -> digest=ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad.
//     -> done pulses exactly 225 edges after the W15 accept.
//  T2 two-block "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq": init once, then two blocks with no init between.
//     -> digest=248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1.
//  T3 backpressure: toggle msg_valid randomly during LOAD; hold msg_valid=1 throughout ROUND.
//     -> Words are taken only when msg_ready=1.
//     -> No word is consumed while busy.
//     -> T1 digest is reproduced.
//  T4 reset mid-block: assert rst for 1 cycle at t=30.
//     -> digest=IV, done never pulses.
//     -> A following T1 run yields the T1 digest.
//  T5 init with msg_valid=1 in IDLE in the same cycle.
//     -> msg_ready=0, word not consumed, H=IV.
//     -> The word is accepted on the next edge once init drops.
//  T6 bus trace at t=16 in T1.
//     -> Cycle 1: sha_opcode=SIG0, sha_rs1=W1=0.
//     -> Cycle 2: SIG1, W14=0.
//     -> Cycle 3: SUM1, rs1=e.
//     -> Cycle 4: SUM0, rs1=a.
//     -> W16=61626380.

Source files
------------

// File: rtl/sha256_compress.sv
// SHA-256 single-block compression engine.
// Takes 16 big-endian message words, runs ROUNDS rounds using an external
// sig0/sig1/sum0/sum1 primitive unit (one op per cycle), then folds the
// working variables into the chaining state H0..H7.
//
//   state | meaning
//   IDLE  | waiting for the first word of a block; init reloads H with the IV
//   LOAD  | collecting words W1..W15
//   ROUND | running round sub-steps on the primitive bus
//   FINAL | adding working variables into H, pulsing done
module sha256_compress #(
  parameter int ROUNDS = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         init,
  input  logic         msg_valid,
  output logic         msg_ready,
  input  logic [31:0]  msg_word,
  output logic         busy,
  output logic         done,
  output logic [255:0] digest,
  output logic [1:0]   sha_opcode,
  output logic [31:0]  sha_rs1,
  input  logic [31:0]  sha_rd
);

  localparam logic [1:0] OP_SIG0 = 2'b00;
  localparam logic [1:0] OP_SIG1 = 2'b01;
  localparam logic [1:0] OP_SUM0 = 2'b10;
  localparam logic [1:0] OP_SUM1 = 2'b11;

  localparam logic [31:0] IV [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_ROUND, ST_FINAL} state_t;
  typedef enum logic [1:0] {STEP_SIG0, STEP_SIG1, STEP_SUM1, STEP_SUM0} step_t;

  state_t      state_q, state_d;
  step_t       step_q, step_d;
  logic [6:0]  t_q, t_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] h_q [8];
  logic [31:0] h_d [8];
  logic [31:0] v_q [8];     // working variables a..h at index 0..7
  logic [31:0] v_d [8];
  logic [31:0] w_q [16];    // rolling message schedule window
  logic [31:0] w_d [16];
  logic [31:0] s0_q, s0_d;
  logic [31:0] s1_q, s1_d;
  logic        done_q, done_d;

  logic [3:0]  idx, idx_p1, idx_m2, idx_m7;
  logic        accept;
  logic [31:0] ch, maj, t1, t2;

  // schedule window indices relative to the current round
  assign idx    = t_q[3:0];
  assign idx_p1 = idx + 4'd1;
  assign idx_m2 = idx - 4'd2;
  assign idx_m7 = idx - 4'd7;

  assign msg_ready = (state_q == ST_IDLE || state_q == ST_LOAD) && !init && !rst;
  assign accept    = msg_valid && msg_ready;
  assign busy      = (state_q == ST_ROUND) || (state_q == ST_FINAL);
  assign done      = done_q;
  assign digest    = {h_q[0], h_q[1], h_q[2], h_q[3], h_q[4], h_q[5], h_q[6], h_q[7]};

  assign ch  = (v_q[4] & v_q[5]) ^ (~v_q[4] & v_q[6]);
  assign maj = (v_q[0] & v_q[1]) ^ (v_q[0] & v_q[2]) ^ (v_q[1] & v_q[2]);
  assign t1  = v_q[7] + s1_q + ch + K[t_q[5:0]] + w_q[idx];
  assign t2  = sha_rd + maj;

  // primitive bus request; kept apart from next-state logic so sha_rd never loops back into it
  always_comb begin
    sha_opcode = 2'b00;
    sha_rs1    = 32'h0;
    if (state_q == ST_ROUND) begin
      case (step_q)
        STEP_SIG0: begin sha_opcode = OP_SIG0; sha_rs1 = w_q[idx_p1]; end
        STEP_SIG1: begin sha_opcode = OP_SIG1; sha_rs1 = w_q[idx_m2]; end
        STEP_SUM1: begin sha_opcode = OP_SUM1; sha_rs1 = v_q[4]; end
        default:   begin sha_opcode = OP_SUM0; sha_rs1 = v_q[0]; end
      endcase
    end
  end

  // next-state: word loading, round sub-steps and final accumulation
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    t_d     = t_q;
    cnt_d   = cnt_q;
    h_d     = h_q;
    v_d     = v_q;
    w_d     = w_q;
    s0_d    = s0_q;
    s1_d    = s1_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE, ST_LOAD: begin
        if (state_q == ST_IDLE && init) begin
          h_d = IV;
        end else if (accept) begin
          w_d[cnt_q] = msg_word;
          cnt_d      = cnt_q + 4'd1;
          state_d    = ST_LOAD;
          if (cnt_q == 4'd15) begin
            state_d = ST_ROUND;
            cnt_d   = 4'd0;
            t_d     = 7'd0;
            step_d  = STEP_SUM1;
            v_d     = h_q;
          end
        end
      end
      ST_ROUND: begin
        case (step_q)
          STEP_SIG0: begin
            s0_d   = sha_rd;
            step_d = STEP_SIG1;
          end
          STEP_SIG1: begin
            w_d[idx] = sha_rd + w_q[idx_m7] + s0_q + w_q[idx];
            step_d   = STEP_SUM1;
          end
          STEP_SUM1: begin
            s1_d   = sha_rd;
            step_d = STEP_SUM0;
          end
          default: begin
            v_d = '{t1 + t2, v_q[0], v_q[1], v_q[2], v_q[3] + t1, v_q[4], v_q[5], v_q[6]};
            t_d = t_q + 7'd1;
            step_d = (t_q >= 7'd15) ? STEP_SIG0 : STEP_SUM1;
            if (t_q == 7'(ROUNDS - 1)) begin
              state_d = ST_FINAL;
              step_d  = STEP_SIG0;
            end
          end
        endcase
      end
      default: begin
        for (int i = 0; i < 8; i++) h_d[i] = h_q[i] + v_q[i];
        done_d  = 1'b1;
        t_d     = 7'd0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // state registers with synchronous reset; reset abandons any block in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      step_q  <= STEP_SIG0;
      t_q     <= 7'd0;
      cnt_q   <= 4'd0;
      h_q     <= IV;
      v_q     <= '{default: 32'h0};
      w_q     <= '{default: 32'h0};
      s0_q    <= 32'h0;
      s1_q    <= 32'h0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      t_q     <= t_d;
      cnt_q   <= cnt_d;
      h_q     <= h_d;
      v_q     <= v_d;
      w_q     <= w_d;
      s0_q    <= s0_d;
      s1_q    <= s1_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_sha256_compress.sv
// Directed bench for sha256_compress: FIPS vectors, backpressure, reset abort,
// init/valid collision and a primitive-bus trace.
module tb_sha256_compress;

  localparam logic [1:0] OP_SIG0 = 2'b00;
  localparam logic [1:0] OP_SIG1 = 2'b01;
  localparam logic [1:0] OP_SUM0 = 2'b10;
  localparam logic [1:0] OP_SUM1 = 2'b11;

  localparam logic [255:0] IV_DIG  = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [255:0] ABC_DIG = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] TWO_DIG = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         init = 1'b0;
  logic         msg_valid = 1'b0;
  logic         msg_ready;
  logic [31:0]  msg_word = 32'h0;
  logic         busy;
  logic         done;
  logic [255:0] digest;
  logic [1:0]   sha_opcode;
  logic [31:0]  sha_rs1;
  logic [31:0]  sha_rd;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int e0 = 0;
  int lat = 0;
  logic [31:0] cur [16];
  logic [31:0] blk_abc [16];
  logic [31:0] blk_m1 [16];
  logic [31:0] blk_m2 [16];

  sha256_compress #(.ROUNDS(64)) dut (
    .clk(clk), .rst(rst), .init(init), .msg_valid(msg_valid), .msg_ready(msg_ready),
    .msg_word(msg_word), .busy(busy), .done(done), .digest(digest),
    .sha_opcode(sha_opcode), .sha_rs1(sha_rs1), .sha_rd(sha_rd)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // shared primitive unit
  always_comb begin
    case (sha_opcode)
      OP_SIG0: sha_rd = rotr(sha_rs1, 7) ^ rotr(sha_rs1, 18) ^ (sha_rs1 >> 3);
      OP_SIG1: sha_rd = rotr(sha_rs1, 17) ^ rotr(sha_rs1, 19) ^ (sha_rs1 >> 10);
      OP_SUM0: sha_rd = rotr(sha_rs1, 2) ^ rotr(sha_rs1, 13) ^ rotr(sha_rs1, 22);
      default: sha_rd = rotr(sha_rs1, 6) ^ rotr(sha_rs1, 11) ^ rotr(sha_rs1, 25);
    endcase
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_init();
    init = 1'b1;
    tick();
    init = 1'b0;
  endtask

  // feeds cur[start..15]; e0 is the cycle stamp right after the W15 accept edge
  task automatic send_block(input int start, input bit bp, input bit hold);
    int i;
    int guard;
    bit acc;
    i = start;
    guard = 0;
    while (i < 16 && guard < 2000) begin
      msg_word  = cur[i];
      msg_valid = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      acc = msg_valid && msg_ready;
      tick();
      if (acc) i++;
      guard++;
    end
    e0 = cyc;
    msg_valid = hold;
    msg_word  = 32'hdeadbeef;
    chk("send_block_complete", 256'(i), 256'd16);
  endtask

  // waits for done; with hold, msg_valid stays high and msg_ready must stay low while busy
  task automatic wait_done(input bit hold, input string tag);
    bit seen;
    bit leak;
    seen = 1'b0;
    leak = 1'b0;
    for (int k = 0; k < 400 && !seen; k++) begin
      tick();
      if (busy && msg_ready) leak = 1'b1;
      if (done) begin
        seen = 1'b1;
        lat = cyc - e0;
        msg_valid = 1'b0;
      end
    end
    msg_valid = 1'b0;
    chk({tag, "_done_seen"}, 256'(seen), 256'd1);
    if (hold) chk({tag, "_ready_low_while_busy"}, 256'(leak), 256'd0);
  endtask

  initial begin
    blk_abc = '{32'h61626380, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
                32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h00000018};
    blk_m1  = '{32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    blk_m2  = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
                32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h000001c0};

    // reset with a word offered: nothing is taken, everything idles
    msg_valid = 1'b1;
    msg_word  = 32'h12345678;
    repeat (3) tick();
    chk("rst_msg_ready", 256'(msg_ready), 256'd0);
    chk("rst_digest", digest, IV_DIG);
    chk("rst_done", 256'(done), 256'd0);
    chk("rst_busy", 256'(busy), 256'd0);
    chk("rst_opcode", 256'(sha_opcode), 256'd0);
    chk("rst_rs1", 256'(sha_rs1), 256'd0);
    msg_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk("idle_msg_ready", 256'(msg_ready), 256'd1);

    // T1 "abc" with T6 bus trace at t=16
    pulse_init();
    cur = blk_abc;
    send_block(0, 1'b0, 1'b0);
    chk("t1_busy_after_w15", 256'(busy), 256'd1);
    repeat (32) tick();
    chk("t6_c1_op", 256'(sha_opcode), 256'(OP_SIG0));
    chk("t6_c1_rs1", 256'(sha_rs1), 256'd0);
    tick();
    chk("t6_c2_op", 256'(sha_opcode), 256'(OP_SIG1));
    chk("t6_c2_rs1", 256'(sha_rs1), 256'd0);
    tick();
    chk("t6_c3_op", 256'(sha_opcode), 256'(OP_SUM1));
    chk("t6_w16", 256'(dut.w_q[0]), 256'h61626380);
    tick();
    chk("t6_c4_op", 256'(sha_opcode), 256'(OP_SUM0));
    wait_done(1'b0, "t1");
    chk("t1_latency", 256'(lat), 256'd225);
    chk("t1_digest", digest, ABC_DIG);
    chk("t1_ready_with_done", 256'(msg_ready), 256'd1);
    tick();
    chk("t1_done_one_cycle", 256'(done), 256'd0);

    // T2 two-block message chained without init between blocks
    pulse_init();
    chk("t2_init_digest", digest, IV_DIG);
    cur = blk_m1;
    send_block(0, 1'b0, 1'b0);
    wait_done(1'b0, "t2_b1");
    cur = blk_m2;
    send_block(0, 1'b0, 1'b0);
    wait_done(1'b0, "t2_b2");
    chk("t2_digest", digest, TWO_DIG);

    // T3 random valid during LOAD, valid held high through ROUND
    pulse_init();
    cur = blk_abc;
    send_block(0, 1'b1, 1'b1);
    wait_done(1'b1, "t3");
    chk("t3_digest", digest, ABC_DIG);

    // T4 reset at t=30 (32 cycles for t<16, then 4 per round)
    pulse_init();
    cur = blk_abc;
    send_block(0, 1'b0, 1'b0);
    repeat (88) tick();
    chk("t4_busy_before_rst", 256'(busy), 256'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t4_digest_iv", digest, IV_DIG);
    chk("t4_busy_cleared", 256'(busy), 256'd0);
    begin
      bit stray;
      stray = 1'b0;
      for (int k = 0; k < 300; k++) begin
        tick();
        if (done || busy) stray = 1'b1;
      end
      chk("t4_no_done", 256'(stray), 256'd0);
    end
    pulse_init();
    send_block(0, 1'b0, 1'b0);
    wait_done(1'b0, "t4_rerun");
    chk("t4_rerun_digest", digest, ABC_DIG);

    // T5 init together with a valid word in IDLE (H currently holds the abc digest)
    init      = 1'b1;
    msg_valid = 1'b1;
    msg_word  = 32'h61626380;
    #1;
    chk("t5_ready_low", 256'(msg_ready), 256'd0);
    tick();
    chk("t5_digest_iv", digest, IV_DIG);
    chk("t5_not_busy", 256'(busy), 256'd0);
    init = 1'b0;
    #1;
    chk("t5_ready_high", 256'(msg_ready), 256'd1);
    tick();
    cur = blk_abc;
    send_block(1, 1'b0, 1'b0);
    wait_done(1'b0, "t5");
    chk("t5_digest", digest, ABC_DIG);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
